// File: rtl/can_decoder_pkg.sv
// Shared types and constants for the CANDecoder bit-level chain.
// Holds intermission state encodings, counter widths and default bit counts.
package can_decoder_pkg;

    localparam int unsigned CNT_W          = 5;
    localparam int unsigned ITM_BIT_W      = 2;
    localparam int unsigned OVRLD_CNT_W    = 2;
    localparam int unsigned INTEG_BITS_DEF = 11;
    localparam int unsigned ITM_BITS_DEF   = 3;
    localparam int unsigned WAIT_MAX_DEF   = 31;

    localparam logic [ITM_BIT_W-1:0] ITM_BIT_LAST = ITM_BIT_W'(ITM_BITS_DEF - 1);

    typedef enum logic [2:0] {
        ITM_INTEG,
        ITM_IDLE,
        ITM_BUSY,
        ITM_ITM,
        ITM_OVWAIT
    } itm_state_e;

    function automatic logic [OVRLD_CNT_W-1:0] ovrld_sat_inc(input logic [OVRLD_CNT_W-1:0] v);
        return (&v) ? v : v + OVRLD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sp_sat_counter.sv
// Saturating clear/increment counter clocked by the sample point.
// hit_c flags that the increment taken on this edge reaches TERM.
module sp_sat_counter
    import can_decoder_pkg::*;
#(
    parameter int unsigned TERM = WAIT_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare the post-increment value so TERM-th sample triggers on its own edge.
    assign hit_c = inc && ((32'(cnt_q) + 32'd1) >= TERM);

endmodule

// File: rtl/intermission_block.sv
// CAN intermission / bus-idle tracker feeding Overload_error_block.
// Build option ITM_BUS_INTEGRATION_EN adds the bus-integration (INTEG) state.
module intermission_block
    import can_decoder_pkg::*;
#(
    parameter int unsigned INTEG_BITS = INTEG_BITS_DEF,
    parameter int unsigned WAIT_MAX   = WAIT_MAX_DEF
) (
    input  logic                   reset,
    input  logic                   SP,
    input  logic                   RX,
    input  logic                   F_EOF,
    input  logic                   F_ITMSS,
    output logic                   F_OVRLD,
    output logic                   F_SOF,
    output logic                   BUS_IDLE,
    output logic [ITM_BIT_W-1:0]   ITM_BIT,
    output logic [OVRLD_CNT_W-1:0] OVRLD_CNT,
    output logic                   TIMEOUT
);

`ifdef ITM_BUS_INTEGRATION_EN
    localparam itm_state_e RST_STATE    = ITM_INTEG;
    localparam itm_state_e WDOG_STATE   = ITM_INTEG;
    localparam logic       RST_BUS_IDLE = 1'b0;
`else
    localparam itm_state_e RST_STATE    = ITM_IDLE;
    localparam itm_state_e WDOG_STATE   = ITM_IDLE;
    localparam logic       RST_BUS_IDLE = 1'b1;
`endif

    itm_state_e             state_q, state_d;
    logic                   f_ovrld_q, f_ovrld_d;
    logic                   f_sof_q, f_sof_d;
    logic                   bus_idle_q, bus_idle_d;
    logic [ITM_BIT_W-1:0]   itm_bit_q, itm_bit_d;
    logic [OVRLD_CNT_W-1:0] ovrld_cnt_q, ovrld_cnt_d;
    logic                   timeout_q, timeout_d;

    logic wait_clr, wait_inc, wait_hit_c;

    sp_sat_counter #(.TERM(WAIT_MAX)) u_wait_cnt (
        .clk   (SP),
        .rst   (reset),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .hit_c (wait_hit_c)
    );

`ifdef ITM_BUS_INTEGRATION_EN
    logic integ_clr, integ_inc, integ_hit_c;

    sp_sat_counter #(.TERM(INTEG_BITS)) u_integ_cnt (
        .clk   (SP),
        .rst   (reset),
        .clr   (integ_clr),
        .inc   (integ_inc),
        .hit_c (integ_hit_c)
    );
`else
    logic integ_bits_unused;
    assign integ_bits_unused = (INTEG_BITS == 32'd0);
`endif

    always_comb begin
        state_d     = state_q;
        f_ovrld_d   = 1'b1;
        f_sof_d     = 1'b1;
        itm_bit_d   = itm_bit_q;
        ovrld_cnt_d = ovrld_cnt_q;
        timeout_d   = timeout_q;
        wait_clr    = 1'b1;
        wait_inc    = 1'b0;
`ifdef ITM_BUS_INTEGRATION_EN
        integ_clr   = 1'b1;
        integ_inc   = 1'b0;
`endif

        case (state_q)
`ifdef ITM_BUS_INTEGRATION_EN
            ITM_INTEG: begin
                integ_clr = !RX;
                integ_inc = RX;
                if (RX && integ_hit_c) begin
                    state_d = ITM_IDLE;
                end
            end
`endif
            ITM_IDLE: begin
                if (!RX) begin
                    f_sof_d = 1'b0;
                    state_d = ITM_BUSY;
                end
            end
            ITM_BUSY: begin
                if (!F_ITMSS) begin
                    state_d   = ITM_ITM;
                    itm_bit_d = '0;
                end
            end
            ITM_ITM: begin
                if (!RX && (itm_bit_q != ITM_BIT_LAST)) begin
                    f_ovrld_d   = 1'b0;
                    ovrld_cnt_d = ovrld_sat_inc(ovrld_cnt_q);
                    state_d     = ITM_OVWAIT;
                end else if (!RX) begin
                    f_sof_d = 1'b0;
                    state_d = ITM_BUSY;
                end else if (itm_bit_q == ITM_BIT_LAST) begin
                    state_d = ITM_IDLE;
                end else begin
                    itm_bit_d = itm_bit_q + ITM_BIT_W'(1);
                end
            end
            ITM_OVWAIT: begin
                wait_clr = 1'b0;
                wait_inc = 1'b1;
                if (!F_ITMSS) begin
                    state_d   = ITM_ITM;
                    itm_bit_d = '0;
                end else if (wait_hit_c) begin
                    timeout_d = 1'b1;
                    state_d   = WDOG_STATE;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase

        // End of frame restarts intermission regardless of anything else this bit.
        if ((state_q != ITM_INTEG) && !F_EOF) begin
            state_d     = ITM_ITM;
            itm_bit_d   = '0;
            ovrld_cnt_d = '0;
            f_ovrld_d   = 1'b1;
            f_sof_d     = 1'b1;
            timeout_d   = timeout_q;
        end

        if (state_d != ITM_ITM) begin
            itm_bit_d = '0;
        end
        bus_idle_d = (state_d == ITM_IDLE);
    end

    always_ff @(posedge SP or posedge reset) begin
        if (reset) begin
            state_q     <= RST_STATE;
            f_ovrld_q   <= 1'b1;
            f_sof_q     <= 1'b1;
            bus_idle_q  <= RST_BUS_IDLE;
            itm_bit_q   <= '0;
            ovrld_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_ovrld_q   <= f_ovrld_d;
            f_sof_q     <= f_sof_d;
            bus_idle_q  <= bus_idle_d;
            itm_bit_q   <= itm_bit_d;
            ovrld_cnt_q <= ovrld_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign F_OVRLD   = f_ovrld_q;
    assign F_SOF     = f_sof_q;
    assign BUS_IDLE  = bus_idle_q;
    assign ITM_BIT   = itm_bit_q;
    assign OVRLD_CNT = ovrld_cnt_q;
    assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_intermission_block.sv
// Directed self-checking bench for intermission_block.
// Expectations follow ITM_BUS_INTEGRATION_EN the same way the design does.
module tb_intermission_block;

    logic       reset;
    logic       SP;
    logic       RX;
    logic       F_EOF;
    logic       F_ITMSS;
    logic       F_OVRLD;
    logic       F_SOF;
    logic       BUS_IDLE;
    logic [1:0] ITM_BIT;
    logic [1:0] OVRLD_CNT;
    logic       TIMEOUT;

    int checks   = 0;
    int failures = 0;

`ifdef ITM_BUS_INTEGRATION_EN
    localparam logic RST_IDLE = 1'b0;
`else
    localparam logic RST_IDLE = 1'b1;
`endif

    intermission_block dut (
        .reset     (reset),
        .SP        (SP),
        .RX        (RX),
        .F_EOF     (F_EOF),
        .F_ITMSS   (F_ITMSS),
        .F_OVRLD   (F_OVRLD),
        .F_SOF     (F_SOF),
        .BUS_IDLE  (BUS_IDLE),
        .ITM_BIT   (ITM_BIT),
        .OVRLD_CNT (OVRLD_CNT),
        .TIMEOUT   (TIMEOUT)
    );

    initial begin
        SP = 1'b0;
        forever #5 SP = ~SP;
    end

    task automatic step();
        @(posedge SP);
        #1;
    endtask

    // IDLE -> SOF -> BUSY -> EOF -> ITM bit 0
    task automatic enter_itm();
        RX = 1'b0; step();
        RX = 1'b1; step();
        F_EOF = 1'b0; step();
        F_EOF = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; RX = 1'b1; F_EOF = 1'b1; F_ITMSS = 1'b1;
        step(); step();
        checks++; if (F_OVRLD !== 1'b1) begin failures++; $display("FAIL rst_ovrld got=%b want=1", F_OVRLD); end
        checks++; if (F_SOF !== 1'b1) begin failures++; $display("FAIL rst_sof got=%b want=1", F_SOF); end
        checks++; if (ITM_BIT !== 2'd0) begin failures++; $display("FAIL rst_itm_bit got=%0d want=0", ITM_BIT); end
        checks++; if (OVRLD_CNT !== 2'd0) begin failures++; $display("FAIL rst_cnt got=%0d want=0", OVRLD_CNT); end
        checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b want=0", TIMEOUT); end
        checks++; if (BUS_IDLE !== RST_IDLE) begin failures++; $display("FAIL rst_bus_idle got=%b want=%b", BUS_IDLE, RST_IDLE); end
        reset = 1'b0;
    endtask

    task automatic test_integration();
`ifdef ITM_BUS_INTEGRATION_EN
        RX = 1'b1; repeat (10) step();
        RX = 1'b0; step();
        RX = 1'b1; repeat (10) step();
        checks++; if (BUS_IDLE !== 1'b0) begin failures++; $display("FAIL integ_edge21 got=%b want=0", BUS_IDLE); end
        step();
        checks++; if (BUS_IDLE !== 1'b1) begin failures++; $display("FAIL integ_edge22 got=%b want=1", BUS_IDLE); end
`else
        RX = 1'b1; repeat (3) step();
        checks++; if (BUS_IDLE !== 1'b1) begin failures++; $display("FAIL idle_hold got=%b want=1", BUS_IDLE); end
`endif
    endtask

    task automatic test_clean_itm();
        RX = 1'b0; step();
        checks++; if (F_SOF !== 1'b0) begin failures++; $display("FAIL clean_sof got=%b want=0", F_SOF); end
        checks++; if (BUS_IDLE !== 1'b0) begin failures++; $display("FAIL clean_busy got=%b want=0", BUS_IDLE); end
        RX = 1'b1; step();
        checks++; if (F_SOF !== 1'b1) begin failures++; $display("FAIL clean_sof_rise got=%b want=1", F_SOF); end
        F_EOF = 1'b0; step(); F_EOF = 1'b1;
        checks++; if (ITM_BIT !== 2'd0) begin failures++; $display("FAIL clean_b0 got=%0d want=0", ITM_BIT); end
        step();
        checks++; if (ITM_BIT !== 2'd1) begin failures++; $display("FAIL clean_b1 got=%0d want=1", ITM_BIT); end
        F_ITMSS = 1'b0; step(); F_ITMSS = 1'b1;
        checks++; if (ITM_BIT !== 2'd2) begin failures++; $display("FAIL clean_itmss_ignored got=%0d want=2", ITM_BIT); end
        step();
        checks++; if (BUS_IDLE !== 1'b1) begin failures++; $display("FAIL clean_idle got=%b want=1", BUS_IDLE); end
        checks++; if (ITM_BIT !== 2'd0) begin failures++; $display("FAIL clean_bit_out got=%0d want=0", ITM_BIT); end
        checks++; if (OVRLD_CNT !== 2'd0) begin failures++; $display("FAIL clean_cnt got=%0d want=0", OVRLD_CNT); end
    endtask

    task automatic test_overload();
        enter_itm();
        RX = 1'b1; step();
        checks++; if (ITM_BIT !== 2'd1) begin failures++; $display("FAIL ovl_b1 got=%0d want=1", ITM_BIT); end
        RX = 1'b0; step();
        checks++; if (F_OVRLD !== 1'b0) begin failures++; $display("FAIL ovl_req got=%b want=0", F_OVRLD); end
        checks++; if (OVRLD_CNT !== 2'd1) begin failures++; $display("FAIL ovl_cnt1 got=%0d want=1", OVRLD_CNT); end
        RX = 1'b1; step();
        checks++; if (F_OVRLD !== 1'b1) begin failures++; $display("FAIL ovl_req_rise got=%b want=1", F_OVRLD); end
        repeat (12) step();
        F_ITMSS = 1'b0; step(); F_ITMSS = 1'b1;
        checks++; if (ITM_BIT !== 2'd0) begin failures++; $display("FAIL ovl_return_b0 got=%0d want=0", ITM_BIT); end
        checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL ovl_no_timeout got=%b want=0", TIMEOUT); end
        RX = 1'b0; step(); RX = 1'b1;
        checks++; if (OVRLD_CNT !== 2'd2) begin failures++; $display("FAIL ovl_cnt2 got=%0d want=2", OVRLD_CNT); end
        F_ITMSS = 1'b0; step(); F_ITMSS = 1'b1;
        RX = 1'b0; step(); RX = 1'b1;
        checks++; if (OVRLD_CNT !== 2'd3) begin failures++; $display("FAIL ovl_cnt3 got=%0d want=3", OVRLD_CNT); end
        F_ITMSS = 1'b0; step(); F_ITMSS = 1'b1;
        RX = 1'b0; step(); RX = 1'b1;
        checks++; if (OVRLD_CNT !== 2'd3) begin failures++; $display("FAIL ovl_cnt_sat got=%0d want=3", OVRLD_CNT); end
        checks++; if (F_OVRLD !== 1'b0) begin failures++; $display("FAIL ovl_req_sat got=%b want=0", F_OVRLD); end
        F_ITMSS = 1'b0; step(); F_ITMSS = 1'b1;
        step(); step();
        checks++; if (ITM_BIT !== 2'd2) begin failures++; $display("FAIL ovl_b2 got=%0d want=2", ITM_BIT); end
        step();
        checks++; if (BUS_IDLE !== 1'b1) begin failures++; $display("FAIL ovl_idle got=%b want=1", BUS_IDLE); end
        checks++; if (OVRLD_CNT !== 2'd3) begin failures++; $display("FAIL ovl_cnt_kept got=%0d want=3", OVRLD_CNT); end
    endtask

    task automatic test_sof_bit2();
        enter_itm();
        checks++; if (OVRLD_CNT !== 2'd0) begin failures++; $display("FAIL sof2_eof_clr got=%0d want=0", OVRLD_CNT); end
        RX = 1'b0; step(); RX = 1'b1;
        F_ITMSS = 1'b0; step(); F_ITMSS = 1'b1;
        step(); step();
        checks++; if (ITM_BIT !== 2'd2) begin failures++; $display("FAIL sof2_b2 got=%0d want=2", ITM_BIT); end
        RX = 1'b0; step(); RX = 1'b1;
        checks++; if (F_SOF !== 1'b0) begin failures++; $display("FAIL sof2_sof got=%b want=0", F_SOF); end
        checks++; if (F_OVRLD !== 1'b1) begin failures++; $display("FAIL sof2_no_ovrld got=%b want=1", F_OVRLD); end
        checks++; if (BUS_IDLE !== 1'b0) begin failures++; $display("FAIL sof2_busy got=%b want=0", BUS_IDLE); end
        step();
        checks++; if (F_SOF !== 1'b1) begin failures++; $display("FAIL sof2_sof_rise got=%b want=1", F_SOF); end
        F_ITMSS = 1'b0; step(); F_ITMSS = 1'b1;
        checks++; if (OVRLD_CNT !== 2'd1) begin failures++; $display("FAIL err_end_cnt_kept got=%0d want=1", OVRLD_CNT); end
        checks++; if (BUS_IDLE !== 1'b0) begin failures++; $display("FAIL err_end_not_idle got=%b want=0", BUS_IDLE); end
        step();
        checks++; if (ITM_BIT !== 2'd1) begin failures++; $display("FAIL err_end_itm got=%0d want=1", ITM_BIT); end
        step(); step();
        checks++; if (BUS_IDLE !== 1'b1) begin failures++; $display("FAIL sof2_idle got=%b want=1", BUS_IDLE); end
    endtask

    task automatic test_watchdog();
        enter_itm();
        RX = 1'b0; step(); RX = 1'b1;
        repeat (30) step();
        checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL wd_early got=%b want=0", TIMEOUT); end
        step();
        checks++; if (TIMEOUT !== 1'b1) begin failures++; $display("FAIL wd_expire got=%b want=1", TIMEOUT); end
`ifdef ITM_BUS_INTEGRATION_EN
        checks++; if (BUS_IDLE !== 1'b0) begin failures++; $display("FAIL wd_integ got=%b want=0", BUS_IDLE); end
        repeat (10) step();
        checks++; if (BUS_IDLE !== 1'b0) begin failures++; $display("FAIL wd_integ10 got=%b want=0", BUS_IDLE); end
        step();
        checks++; if (BUS_IDLE !== 1'b1) begin failures++; $display("FAIL wd_integ11 got=%b want=1", BUS_IDLE); end
`else
        checks++; if (BUS_IDLE !== 1'b1) begin failures++; $display("FAIL wd_idle got=%b want=1", BUS_IDLE); end
`endif
        step();
        checks++; if (TIMEOUT !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%b want=1", TIMEOUT); end
    endtask

    task automatic test_eof_priority();
        enter_itm();
        RX = 1'b0; step(); RX = 1'b1;
        step();
        RX = 1'b0; F_EOF = 1'b0; F_ITMSS = 1'b0; step();
        RX = 1'b1; F_EOF = 1'b1; F_ITMSS = 1'b1;
        checks++; if (ITM_BIT !== 2'd0) begin failures++; $display("FAIL eof_ovwait_b0 got=%0d want=0", ITM_BIT); end
        checks++; if (OVRLD_CNT !== 2'd0) begin failures++; $display("FAIL eof_ovwait_cnt got=%0d want=0", OVRLD_CNT); end
        checks++; if (F_OVRLD !== 1'b1) begin failures++; $display("FAIL eof_ovwait_ovrld got=%b want=1", F_OVRLD); end
        step();
        checks++; if (ITM_BIT !== 2'd1) begin failures++; $display("FAIL eof_ovwait_itm got=%0d want=1", ITM_BIT); end
        step(); step();
        RX = 1'b0; F_EOF = 1'b0; step();
        RX = 1'b1; F_EOF = 1'b1;
        checks++; if (F_SOF !== 1'b1) begin failures++; $display("FAIL eof_idle_no_sof got=%b want=1", F_SOF); end
        checks++; if (BUS_IDLE !== 1'b0) begin failures++; $display("FAIL eof_idle_left got=%b want=0", BUS_IDLE); end
        step();
        checks++; if (ITM_BIT !== 2'd1) begin failures++; $display("FAIL eof_idle_itm got=%0d want=1", ITM_BIT); end
        step(); step();
    endtask

    task automatic test_reset_midpulse();
        enter_itm();
        RX = 1'b0; step(); RX = 1'b1;
        checks++; if (F_OVRLD !== 1'b0) begin failures++; $display("FAIL mid_ovrld_low got=%b want=0", F_OVRLD); end
        #2 reset = 1'b1;
        #1;
        checks++; if (F_OVRLD !== 1'b1) begin failures++; $display("FAIL mid_rst_ovrld got=%b want=1", F_OVRLD); end
        checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL mid_rst_timeout got=%b want=0", TIMEOUT); end
        checks++; if (OVRLD_CNT !== 2'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d want=0", OVRLD_CNT); end
        checks++; if (BUS_IDLE !== RST_IDLE) begin failures++; $display("FAIL mid_rst_idle got=%b want=%b", BUS_IDLE, RST_IDLE); end
        step();
        reset = 1'b0;
        step();
        checks++; if (F_OVRLD !== 1'b1) begin failures++; $display("FAIL post_rst_ovrld got=%b want=1", F_OVRLD); end
        checks++; if (BUS_IDLE !== RST_IDLE) begin failures++; $display("FAIL post_rst_idle got=%b want=%b", BUS_IDLE, RST_IDLE); end
    endtask

    initial begin
        test_reset();
        test_integration();
        test_clean_itm();
        test_overload();
        test_sof_bit2();
        test_watchdog();
        test_eof_priority();
        test_reset_midpulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
